// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI constants, burst-master state enum and size helper
package axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [3:0] AXI_CACHE_BUF   = 4'b0011;
   localparam logic       AXI_LOCK_NORMAL = 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      FINISH
   } state_t;

   function automatic logic [2:0] size_from_width(input int unsigned width);
      case (width)
         8:       return 3'd0;
         16:      return 3'd1;
         32:      return 3'd2;
         64:      return 3'd3;
         128:     return 3'd4;
         default: return 3'd2;
      endcase
   endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// rtl/axi_beat_counter.sv - beat counter shared by write and read data phases
module axi_beat_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       inc,
   input  logic [3:0] len,
   output logic [4:0] count,
   output logic       last
);

   logic [4:0] count_q, count_d;

   // One extra bit lets a read overrun past len be seen; saturate instead of wrapping.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = 5'd0;
      end else if (inc && (count_q != 5'h1f)) begin
         count_d = count_q + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 5'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign last  = (count_q == {1'b0, len});

endmodule

// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-burst AXI4 master driven by a simple request channel
module axi_burst_master
   import axi_pkg::*;
#(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_AXI_ADDR_WIDTH = 32,
   parameter int C_MAX_BURST      = 16
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_write,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   req_addr,
   input  logic [3:0]                    req_len,
   input  logic                          wdata_valid,
   output logic                          wdata_ready,
   input  logic [C_AXI_DATA_WIDTH-1:0]   wdata,
   output logic                          rdata_valid,
   output logic [C_AXI_DATA_WIDTH-1:0]   rdata,
   output logic                          rdata_last,
   output logic                          done_valid,
   output logic                          done_err,
   output logic [3:0]                    AWID,
   output logic [C_AXI_ADDR_WIDTH-1:0]   AWADDR,
   output logic [7:0]                    AWLEN,
   output logic [2:0]                    AWSIZE,
   output logic [1:0]                    AWBURST,
   output logic                          AWLOCK,
   output logic [3:0]                    AWCACHE,
   output logic [2:0]                    AWPROT,
   output logic [3:0]                    AWQOS,
   output logic                          AWUSER,
   output logic                          AWVALID,
   input  logic                          AWREADY,
   output logic [C_AXI_DATA_WIDTH-1:0]   WDATA,
   output logic [C_AXI_DATA_WIDTH/8-1:0] WSTRB,
   output logic                          WLAST,
   output logic                          WUSER,
   output logic                          WVALID,
   input  logic                          WREADY,
   input  logic [1:0]                    BRESP,
   input  logic                          BVALID,
   output logic                          BREADY,
   output logic [3:0]                    ARID,
   output logic [C_AXI_ADDR_WIDTH-1:0]   ARADDR,
   output logic [7:0]                    ARLEN,
   output logic [2:0]                    ARSIZE,
   output logic [1:0]                    ARBURST,
   output logic                          ARLOCK,
   output logic [3:0]                    ARCACHE,
   output logic [2:0]                    ARPROT,
   output logic [3:0]                    ARQOS,
   output logic                          ARUSER,
   output logic                          ARVALID,
   input  logic                          ARREADY,
   input  logic [C_AXI_DATA_WIDTH-1:0]   RDATA,
   input  logic [1:0]                    RRESP,
   input  logic                          RLAST,
   input  logic                          RVALID,
   output logic                          RREADY
);

   localparam int         BYTES   = C_AXI_DATA_WIDTH / 8;
   localparam int         LSB     = int'(size_from_width(C_AXI_DATA_WIDTH));
   localparam logic [3:0] MAX_LEN = 4'(C_MAX_BURST - 1);
   localparam logic [C_AXI_ADDR_WIDTH-1:0] ADDR_KEEP =
      {{(C_AXI_ADDR_WIDTH - LSB){1'b1}}, {LSB{1'b0}}};

   state_t                      state_q, state_d;
   logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [3:0]                  len_q, len_d;
   logic                        err_q, err_d;

   logic [C_AXI_ADDR_WIDTH-1:0] req_addr_al;
   logic [3:0]                  req_len_eff;
   logic [13:0]                 span;
   logic                        crosses_4k;
   logic                        accept;
   logic                        cnt_load, cnt_inc, cnt_last, cnt_under;
   logic [4:0]                  cnt_count;
   logic                        unused_resp;

   assign req_addr_al = req_addr & ADDR_KEEP;
   assign req_len_eff = (req_len > MAX_LEN) ? MAX_LEN : req_len;
   assign span        = {2'b00, req_addr_al[11:0]} + (14'(req_len_eff) + 14'd1) * 14'(BYTES);
   assign crosses_4k  = (span > 14'd4096);
   assign accept      = req_valid && req_ready;
   assign cnt_under   = (cnt_count < {1'b0, len_q});
   assign unused_resp = ^{BRESP[0], RRESP[0]};

   axi_beat_counter u_beat_counter (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .load  (cnt_load),
      .inc   (cnt_inc),
      .len   (len_q),
      .count (cnt_count),
      .last  (cnt_last)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      err_d       = err_q;
      cnt_load    = 1'b0;
      cnt_inc     = 1'b0;
      // req_ready is qualified by reset so nothing looks acceptable while held in reset
      req_ready   = (state_q == IDLE) && ARESETN;
      AWVALID     = 1'b0;
      WVALID      = 1'b0;
      WLAST       = 1'b0;
      wdata_ready = 1'b0;
      BREADY      = 1'b0;
      ARVALID     = 1'b0;
      RREADY      = 1'b0;
      rdata_valid = 1'b0;
      rdata_last  = 1'b0;
      done_valid  = 1'b0;
      done_err    = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d   = req_addr_al;
               len_d    = req_len_eff;
               err_d    = crosses_4k;
               cnt_load = 1'b1;
               if (crosses_4k) begin
                  state_d = FINISH;
               end else if (req_write) begin
                  state_d = WR_ADDR;
               end else begin
                  state_d = RD_ADDR;
               end
            end
         end
         WR_ADDR: begin
            AWVALID = 1'b1;
            if (AWREADY) begin
               state_d = WR_DATA;
            end
         end
         WR_DATA: begin
            WVALID      = wdata_valid;
            wdata_ready = WREADY;
            WLAST       = cnt_last;
            if (wdata_valid && WREADY) begin
               cnt_inc = 1'b1;
               if (cnt_last) begin
                  state_d = WR_RESP;
               end
            end
         end
         WR_RESP: begin
            BREADY = 1'b1;
            if (BVALID) begin
               err_d   = BRESP[1];
               state_d = FINISH;
            end
         end
         RD_ADDR: begin
            ARVALID = 1'b1;
            if (ARREADY) begin
               state_d = RD_DATA;
            end
         end
         RD_DATA: begin
            RREADY = 1'b1;
            if (RVALID) begin
               rdata_valid = 1'b1;
               rdata_last  = RLAST;
               cnt_inc     = 1'b1;
               // RLAST must coincide with beat len: early RLAST, or a non-final beat at/after len, is an error
               err_d = err_q | RRESP[1] | (RLAST ? cnt_under : !cnt_under);
               if (RLAST) begin
                  state_d = FINISH;
               end
            end
         end
         FINISH: begin
            done_valid = 1'b1;
            done_err   = err_q;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         err_q   <= err_d;
      end
   end

   assign rdata   = RDATA;
   assign WDATA   = wdata;
   assign WSTRB   = '1;
   assign WUSER   = 1'b0;

   assign AWID    = 4'd0;
   assign AWADDR  = addr_q;
   assign AWLEN   = {4'd0, len_q};
   assign AWSIZE  = size_from_width(C_AXI_DATA_WIDTH);
   assign AWBURST = AXI_BURST_INCR;
   assign AWLOCK  = AXI_LOCK_NORMAL;
   assign AWCACHE = AXI_CACHE_BUF;
   assign AWPROT  = 3'd0;
   assign AWQOS   = 4'd0;
   assign AWUSER  = 1'b0;

   assign ARID    = 4'd0;
   assign ARADDR  = addr_q;
   assign ARLEN   = {4'd0, len_q};
   assign ARSIZE  = size_from_width(C_AXI_DATA_WIDTH);
   assign ARBURST = AXI_BURST_INCR;
   assign ARLOCK  = AXI_LOCK_NORMAL;
   assign ARCACHE = AXI_CACHE_BUF;
   assign ARPROT  = 3'd0;
   assign ARQOS   = 4'd0;
   assign ARUSER  = 1'b0;

endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - directed and randomized bench for axi_burst_master
module tb_axi_burst_master;

   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int MAXB = 8;
   localparam int BYTES = DW / 8;

   logic          ACLK, ARESETN;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [3:0]    req_len;
   logic          wdata_valid, wdata_ready;
   logic [DW-1:0] wdata;
   logic          rdata_valid, rdata_last;
   logic [DW-1:0] rdata;
   logic          done_valid, done_err;
   logic [3:0]    AWID, ARID;
   logic [AW-1:0] AWADDR, ARADDR;
   logic [7:0]    AWLEN, ARLEN;
   logic [2:0]    AWSIZE, ARSIZE, AWPROT, ARPROT;
   logic [1:0]    AWBURST, ARBURST;
   logic          AWLOCK, ARLOCK, AWUSER, ARUSER, WUSER;
   logic [3:0]    AWCACHE, ARCACHE, AWQOS, ARQOS;
   logic          AWVALID, AWREADY, ARVALID, ARREADY;
   logic [DW-1:0] WDATA, RDATA;
   logic [DW/8-1:0] WSTRB;
   logic          WLAST, WVALID, WREADY;
   logic [1:0]    BRESP, RRESP;
   logic          BVALID, BREADY, RLAST, RVALID, RREADY;

   int n_pass  = 0;
   int n_total = 0;

   axi_burst_master #(
      .C_AXI_DATA_WIDTH (DW),
      .C_AXI_ADDR_WIDTH (AW),
      .C_MAX_BURST      (MAXB)
   ) dut (
      .ACLK (ACLK), .ARESETN (ARESETN),
      .req_valid (req_valid), .req_ready (req_ready), .req_write (req_write),
      .req_addr (req_addr), .req_len (req_len),
      .wdata_valid (wdata_valid), .wdata_ready (wdata_ready), .wdata (wdata),
      .rdata_valid (rdata_valid), .rdata (rdata), .rdata_last (rdata_last),
      .done_valid (done_valid), .done_err (done_err),
      .AWID (AWID), .AWADDR (AWADDR), .AWLEN (AWLEN), .AWSIZE (AWSIZE),
      .AWBURST (AWBURST), .AWLOCK (AWLOCK), .AWCACHE (AWCACHE), .AWPROT (AWPROT),
      .AWQOS (AWQOS), .AWUSER (AWUSER), .AWVALID (AWVALID), .AWREADY (AWREADY),
      .WDATA (WDATA), .WSTRB (WSTRB), .WLAST (WLAST), .WUSER (WUSER),
      .WVALID (WVALID), .WREADY (WREADY),
      .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
      .ARID (ARID), .ARADDR (ARADDR), .ARLEN (ARLEN), .ARSIZE (ARSIZE),
      .ARBURST (ARBURST), .ARLOCK (ARLOCK), .ARCACHE (ARCACHE), .ARPROT (ARPROT),
      .ARQOS (ARQOS), .ARUSER (ARUSER), .ARVALID (ARVALID), .ARREADY (ARREADY),
      .RDATA (RDATA), .RRESP (RRESP), .RLAST (RLAST), .RVALID (RVALID), .RREADY (RREADY)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge ACLK);
      @(negedge ACLK);
   endtask

   // Reference model: clamp length, align address, 4KB rule.
   function automatic int eff_len(input int len);
      return (len > MAXB - 1) ? MAXB - 1 : len;
   endfunction

   function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
      return a & ~AW'(BYTES - 1);
   endfunction

   function automatic bit crosses(input logic [AW-1:0] a, input int len);
      logic [AW-1:0] al;
      al = align(a);
      return (int'(al[11:0]) + (eff_len(len) + 1) * BYTES) > 4096;
   endfunction

   task automatic accept_req(input logic wr, input logic [AW-1:0] a, input logic [3:0] len);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_len   = len;
      #1 chk("req_ready", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic finish_checks(input logic exp_err);
      #1;
      chk("done_valid", done_valid, 1'b1);
      chk("done_err", done_err, exp_err);
      tick();
      #1;
      chk("done_pulse_end", done_valid, 1'b0);
      chk("req_ready_back", req_ready, 1'b1);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input int len, input int aw_delay,
                           input logic [1:0] bresp, input bit rand_hs);
      int eff, beat, cyc;
      logic v, r;
      logic [DW-1:0] d;
      eff = eff_len(len);
      accept_req(1'b1, a, 4'(len));
      if (crosses(a, len)) begin
         #1 chk("wr_cross_no_awvalid", AWVALID, 1'b0);
         finish_checks(1'b1);
         return;
      end
      #1;
      chk("awvalid", AWVALID, 1'b1);
      chk("awaddr", AWADDR, align(a));
      chk("awlen", AWLEN, 8'(eff));
      for (int k = 0; k < aw_delay; k++) begin
         AWREADY = 1'b0;
         tick();
         #1;
         chk("awvalid_hold", AWVALID, 1'b1);
         chk("awaddr_hold", AWADDR, align(a));
         chk("awlen_hold", AWLEN, 8'(eff));
      end
      AWREADY = 1'b1;
      tick();
      AWREADY = 1'b0;
      beat = 0;
      cyc  = 0;
      while (beat <= eff && cyc < 200) begin
         v = rand_hs ? (($urandom % 4) != 0) : 1'b1;
         r = rand_hs ? (($urandom % 4) != 0) : 1'b1;
         d = $urandom;
         wdata_valid = v;
         wdata       = d;
         WREADY      = r;
         #1;
         chk("wvalid", WVALID, v);
         chk("wdata_ready", wdata_ready, r);
         if (v) begin
            chk("wlast", WLAST, (beat == eff));
            chk("wdata", WDATA, d);
         end
         tick();
         if (v && r) beat++;
         cyc++;
      end
      wdata_valid = 1'b0;
      WREADY      = 1'b0;
      chk("wr_beats", beat, eff + 1);
      #1 chk("bready", BREADY, 1'b1);
      BVALID = 1'b1;
      BRESP  = bresp;
      tick();
      BVALID = 1'b0;
      BRESP  = 2'b00;
      finish_checks(bresp[1]);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int len, input bit gapped,
                          input int err_beat, input int last_at_in);
      int eff, last_at;
      logic exp_err;
      logic [DW-1:0] d;
      eff = eff_len(len);
      last_at = (last_at_in < 0) ? eff : last_at_in;
      accept_req(1'b0, a, 4'(len));
      if (crosses(a, len)) begin
         #1 chk("rd_cross_no_arvalid", ARVALID, 1'b0);
         finish_checks(1'b1);
         return;
      end
      #1;
      chk("arvalid", ARVALID, 1'b1);
      chk("araddr", ARADDR, align(a));
      chk("arlen", ARLEN, 8'(eff));
      ARREADY = 1'b1;
      tick();
      ARREADY = 1'b0;
      exp_err = (last_at != eff);
      for (int j = 0; j <= last_at; j++) begin
         if (gapped) begin
            RVALID = 1'b0;
            #1 chk("rdata_valid_gap", rdata_valid, 1'b0);
            tick();
         end
         d = $urandom;
         RVALID = 1'b1;
         RDATA  = d;
         RRESP  = (j == err_beat) ? 2'b10 : 2'b00;
         RLAST  = (j == last_at);
         if (j == err_beat) exp_err = 1'b1;
         #1;
         chk("rready", RREADY, 1'b1);
         chk("rdata_valid", rdata_valid, 1'b1);
         chk("rdata", rdata, d);
         chk("rdata_last", rdata_last, (j == last_at));
         tick();
      end
      RVALID = 1'b0;
      RLAST  = 1'b0;
      RRESP  = 2'b00;
      finish_checks(exp_err);
   endtask

   initial begin
      logic [AW-1:0] ra;
      ARESETN = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = 4'd0;
      wdata_valid = 1'b0; wdata = '0;
      AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
      BVALID = 1'b0; BRESP = 2'b00;
      RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0;
      tick();
      tick();
      #1;
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_awvalid", AWVALID, 1'b0);
      chk("rst_arvalid", ARVALID, 1'b0);
      chk("rst_wvalid", WVALID, 1'b0);
      chk("rst_bready", BREADY, 1'b0);
      chk("rst_rready", RREADY, 1'b0);
      chk("rst_done_valid", done_valid, 1'b0);
      chk("rst_rdata_valid", rdata_valid, 1'b0);
      chk("rst_wdata_ready", wdata_ready, 1'b0);
      chk("rst_awaddr", AWADDR, 0);
      chk("rst_araddr", ARADDR, 0);
      chk("awsize", AWSIZE, 3'd2);
      chk("arburst", ARBURST, 2'b01);
      chk("awcache", AWCACHE, 4'b0011);
      chk("wstrb", WSTRB, 4'hF);
      chk("awid", AWID, 4'd0);
      tick();
      ARESETN = 1'b1;
      #1 chk("post_rst_req_ready", req_ready, 1'b1);
      tick();

      do_write(32'h0000_0100, 3, 0, 2'b00, 1'b0);
      do_read (32'h0000_2000, 7, 1'b1, -1, -1);
      do_write(32'h0000_0FF8, 3, 0, 2'b00, 1'b0);
      do_read (32'h0000_0400, 3, 1'b0, 1, -1);
      do_write(32'h0000_0500, 2, 5, 2'b00, 1'b1);
      do_write(32'h0000_0600, 1, 0, 2'b10, 1'b1);
      do_read (32'h0000_0700, 5, 1'b0, -1, 2);
      do_read (32'h0000_0800, 2, 1'b0, -1, 4);
      do_read (32'h0000_1003, 15, 1'b0, -1, -1);

      // Reset during WR_DATA abandons the burst silently.
      accept_req(1'b1, 32'h0000_0300, 4'd5);
      #1 chk("mid_awvalid", AWVALID, 1'b1);
      AWREADY = 1'b1;
      tick();
      AWREADY = 1'b0;
      wdata_valid = 1'b1;
      WREADY = 1'b1;
      #1 chk("mid_wvalid", WVALID, 1'b1);
      tick();
      ARESETN = 1'b0;
      #1;
      chk("mid_rst_wvalid", WVALID, 1'b0);
      chk("mid_rst_wdata_ready", wdata_ready, 1'b0);
      chk("mid_rst_req_ready", req_ready, 1'b0);
      chk("mid_rst_awaddr", AWADDR, 0);
      tick();
      #1 chk("mid_rst_no_done", done_valid, 1'b0);
      ARESETN = 1'b1;
      wdata_valid = 1'b0;
      WREADY = 1'b0;
      #1 chk("mid_rst_idle", req_ready, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         #1 chk("mid_rst_no_done_after", done_valid, 1'b0);
      end
      tick();

      for (int t = 0; t < 24; t++) begin
         ra = $urandom;
         if ($urandom % 2) ra[11:0] = 12'hFC0 | 12'($urandom % 64);
         if ($urandom % 2)
            do_write(ra, int'($urandom % 16), int'($urandom % 3), 2'($urandom), 1'b1);
         else
            do_read(ra, int'($urandom % 16), 1'($urandom),
                    (($urandom % 3) == 0) ? int'($urandom % 8) : -1, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 Parameter C_AXI_DATA_WIDTH, default 32, AXI data width (32 or 64).
REQ-002 Parameter C_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-003 Parameter C_MAX_BURST, default 16, maximum beats per burst (1..16).
REQ-004 Port ACLK, in, 1, the single clock; all logic is rising-edge.
REQ-005 Port ARESETN, in, 1, asynchronous active-low reset.
REQ-006 Ports req_valid (in, 1), req_ready (out, 1), req_write (in, 1), req_addr (in, C_AXI_ADDR_WIDTH) and req_len (in, 4, beats-1) form the user request channel.
REQ-007 Ports wdata_valid (in, 1), wdata_ready (out, 1) and wdata (in, C_AXI_DATA_WIDTH) form the user write-data stream.
REQ-008 Ports rdata_valid (out, 1), rdata (out, C_AXI_DATA_WIDTH) and rdata_last (out, 1) form the user read-data stream, which has no backpressure.
REQ-009 Ports done_valid (out, 1) and done_err (out, 1) form a one-cycle completion pulse with its error flag.
REQ-010 AW channel: AWADDR, AWLEN[7:0], AWVALID (out) and AWREADY (in).
REQ-011 W channel: WDATA, WSTRB[C_AXI_DATA_WIDTH/8], WLAST, WVALID (out) and WREADY (in).
REQ-012 B channel: BRESP[1:0], BVALID (in) and BREADY (out).
REQ-013 AR channel: ARADDR, ARLEN[7:0], ARVALID (out) and ARREADY (in).
REQ-014 R channel: RDATA, RRESP[1:0], RLAST, RVALID (in) and RREADY (out).
REQ-015 Tied-off outputs: AWID/ARID=0, AW/ARBURST=INCR (2'b01), AW/ARSIZE=log2(C_AXI_DATA_WIDTH/8), AW/ARLOCK=0, AW/ARCACHE=4'b0011, AW/ARPROT=0, AW/ARQOS=0, AW/AR/WUSER=0, WSTRB all ones.

Function
REQ-016 The FSM SHALL use the states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA and FINISH.
REQ-017 req_ready=1 only in IDLE; a request is accepted on req_valid&&req_ready, which latches addr, len and write.
REQ-018 The latched address has its low log2(C_AXI_DATA_WIDTH/8) bits forced to zero.
REQ-019 Effective length = min(req_len, C_MAX_BURST-1); AWLEN/ARLEN = effective length, zero-extended.
REQ-020 4KB check: if addr[11:0] + (len+1)*bytes > 4096, go IDLE->FINISH with done_err=1 and issue no AXI transfer.
REQ-021 WR_ADDR: AWVALID=1 and held stable until AWREADY, then go to WR_DATA; AW is always issued before W.
REQ-022 WR_DATA: WVALID = wdata_valid, wdata_ready = WREADY, WDATA = wdata; a beat transfers on WVALID&&WREADY.
REQ-023 The beat counter counts up from 0; WLAST=1 when count==len; the last beat moves the FSM to WR_RESP.
REQ-024 WR_RESP: BREADY=1; on BVALID, err = BRESP[1], then go to FINISH.
REQ-025 RD_ADDR: ARVALID held until ARREADY, then go to RD_DATA.
REQ-026 RD_DATA: RREADY=1; each RVALID beat drives rdata_valid=1 and rdata=RDATA in the same cycle, and rdata_last=RLAST.
REQ-027 err |= RRESP[1] on every read beat (sticky per request).
REQ-028 The read terminates on RLAST; if RLAST arrives before count==len, err is set; if count exceeds len without RLAST, err is set and the FSM exits on RLAST.
REQ-029 FINISH: done_valid=1 for exactly one cycle with done_err=err, then go to IDLE; err clears on accept.
REQ-030 Request-to-AW/ARVALID latency is 1 cycle; back-to-back requests are spaced by at least the FINISH cycle.

Reset
REQ-031 ARESETN low SHALL immediately force state=IDLE, counter=0 and err=0.
REQ-032 While ARESETN is low, all VALID/READY outputs, done_valid, rdata_valid and wdata_ready are 0, and AWADDR/ARADDR are 0.
REQ-033 Reset mid-burst abandons the transfer; no done pulse is produced for it.

Structure
REQ-034 A shared package axi_pkg holds the BURST/CACHE/LOCK constants, the state enum and a size-from-width function.
REQ-035 A sub-module axi_beat_counter (load, inc, len, last) is used for both WR_DATA and RD_DATA.

Verification
REQ-036 Write, addr 0x100, len 3, AWREADY/WREADY always 1 -> AWLEN=3, 4 W beats, WLAST on beat 4, BRESP=0 -> done_err=0.
REQ-037 Read, addr 0x2000, len 7, RVALID gapped every other cycle -> 8 rdata_valid pulses, rdata_last with beat 8, done_err=0.
REQ-038 Write, addr 0xFF8, len 3 at 32-bit (crosses 4KB) -> no AWVALID, done_valid with done_err=1.
REQ-039 Read, len 3, RRESP=2'b10 on beat 2 -> all 4 beats delivered, done_err=1.
REQ-040 AWREADY held low for 5 cycles -> AWADDR/AWLEN stable and AWVALID held; ARESETN low during WR_DATA -> WVALID=0 immediately, IDLE, no done pulse.
